// File: rtl/banked_mem_responder_pkg.sv
// Shared sizing constants, types and the bank-select helper for the banked
// memory responder.
package banked_mem_responder_pkg;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 16;
  localparam int NUM_BANKS    = 4;
  localparam int BANK_BUSY    = 4;
  localparam int READ_LAT     = 2;
  localparam int BANK_SEL_LSB = 1;

  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int CNT_W     = $clog2(BANK_BUSY);
  localparam int MEM_WORDS = 1 << (ADDR_W - 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W-2:0] word_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [BANK_W-1:0] bank_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } bank_state_e;

  typedef struct packed {
    logic  valid;
    data_t data;
  } rd_pipe_t;

  // Words are interleaved across banks, so the bank is the low word-address bits.
  function automatic bank_t bank_idx(input addr_t a);
    return a[BANK_SEL_LSB +: BANK_W];
  endfunction

endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bus between the cache controller (master) and the banked
// memory responder (slave).
interface banked_mem_responder_if;
  import banked_mem_responder_pkg::*;

  addr_t                addr;
  data_t                data_in;
  logic                 wr;
  logic                 rd;
  data_t                data_out;
  logic                 rd_valid;
  logic                 stall;
  logic [NUM_BANKS-1:0] busy;
  logic                 err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, rd_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, rd_valid, stall, busy, err
  );

endinterface

// File: rtl/banked_mem_responder_bank_busy_ctr.sv
// Per-bank occupancy tracker: a load starts a BANK_BUSY-1 cycle busy window,
// after which the bank returns to idle.
module bank_busy_ctr
  import banked_mem_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(BANK_BUSY - 1);
  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(1);

  bank_state_e      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Count stays pinned at zero while idle, so it never wraps.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_BUSY;
          count_d = LOAD_VAL;
        end
      end
      ST_BUSY: begin
        if (count_q == LAST_VAL) begin
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  assign busy = (count_q != '0);

endmodule

// File: rtl/banked_mem_responder.sv
// Word-interleaved banked main memory: single-word reads/writes, fixed read
// latency, per-bank busy tracking and stall/err reporting.
module banked_mem_responder
  import banked_mem_responder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  banked_mem_responder_if.slave bus
);

  logic                 req;
  logic                 illegal;
  logic                 stall;
  logic                 accept;
  logic                 rd_accept;
  bank_t                bank;
  word_t                word_idx;
  logic [NUM_BANKS-1:0] busy;
  logic [NUM_BANKS-1:0] load;
  logic                 err_q, err_d;
  rd_pipe_t             pipe_q [READ_LAT];
  rd_pipe_t             pipe_d [READ_LAT];
  data_t                mem    [MEM_WORDS];

  // Illegal requests never stall, so stall only looks at legal single requests.
  always_comb begin
    req       = bus.rd ^ bus.wr;
    illegal   = (bus.rd & bus.wr) | ((bus.rd | bus.wr) & bus.addr[0]);
    bank      = bank_idx(bus.addr);
    word_idx  = bus.addr[ADDR_W-1:1];
    stall     = req & ~illegal & busy[bank];
    accept    = req & ~illegal & ~busy[bank];
    rd_accept = accept & bus.rd;
    err_d     = illegal;
    load      = '0;
    load[bank] = accept;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_busy_ctr u_ctr (
      .clk  (clk),
      .rst  (rst),
      .load (load[b]),
      .busy (busy[b])
    );
  end

  // Read data is captured at accept time and then shifted, preserving order.
  always_comb begin
    for (int i = 0; i < READ_LAT; i++) begin
      pipe_d[i] = '0;
    end
    pipe_d[0].valid = rd_accept;
    pipe_d[0].data  = rd_accept ? mem[word_idx] : '0;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Storage has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!rst && accept && bus.wr) begin
      mem[word_idx] <= bus.data_in;
    end
  end

  assign bus.stall    = stall;
  assign bus.busy     = busy;
  assign bus.err      = err_q;
  assign bus.rd_valid = pipe_q[READ_LAT-1].valid;
  assign bus.data_out = pipe_q[READ_LAT-1].valid ? pipe_q[READ_LAT-1].data : '0;

endmodule
